alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
- REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk, input, 1, single clock; all state updates on the rising edge.
  - rst_n, input, 1, asynchronous active-low reset.
  - in_valid, input, 1, an instruction is offered.
  - in_ready, output, 1, the block accepts the instruction this cycle.
  - instr, input, 32, RV32I instruction word.
  - pc, input, 32, address of the instruction.
  - rs1_data, input, 32, register-file value for instr[19:15].
  - rs2_data, input, 32, register-file value for instr[24:20].
  - out_valid, output, 1, a registered ALU operation is presented.
  - out_ready, input, 1, the ALU/writeback consumer accepts the operation.
  - alu_op, output, 4, ALU opcode {mod bit, funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - in1, output, 32, ALU operand 1.
  - in2, output, 32, ALU operand 2.
  - rd, output, 5, destination register index.
  - wb_en, output, 1, the result is to be written to rd.
  - illegal, output, 1, the instruction is not decodable by this block.
- REQ-002 The block SHALL use exactly one clock and an asynchronous active-low reset, with ports named clk and rst_n.

Function
- REQ-003 The block SHALL be a one-entry registered pipeline stage, with in_ready = ~out_valid | out_ready.
- REQ-004 A transfer in SHALL occur when in_valid & in_ready; a transfer out SHALL occur when out_valid & out_ready.
- REQ-005 On a transfer in, all outputs SHALL be loaded on the same edge and out_valid set to 1, giving a latency of 1 cycle.
- REQ-006 On a transfer out with no transfer in, out_valid SHALL clear to 0.
- REQ-007 A simultaneous transfer out and transfer in SHALL replace the entry with no bubble, sustaining 1 operation per cycle.
- REQ-008 While out_valid=1 and out_ready=0, all outputs SHALL hold stable and in_ready SHALL be 0.
- REQ-009 OP (opcode 0110011) SHALL decode as: alu_op = {instr[30], funct3}; in1 = rs1_data; in2 = rs2_data.
- REQ-010 OP-IMM (opcode 0010011) SHALL decode as: in1 = rs1_data; in2 = the sign-extended instr[31:20].
  - For funct3 001 and 101, in2 SHALL instead be {27'b0, instr[24:20]} and alu_op = {instr[30], funct3}.
  - For all other funct3, alu_op = {0, funct3}; bit 30 SHALL NOT produce SUB.
- REQ-011 LUI (opcode 0110111) SHALL decode as: alu_op = ADD; in1 = 0; in2 = {instr[31:12], 12'b0}.
- REQ-012 AUIPC (opcode 0010111) SHALL decode as: alu_op = ADD; in1 = pc; in2 = {instr[31:12], 12'b0}.
- REQ-013 Any other opcode SHALL set illegal = 1, wb_en = 0, alu_op = ADD, and in1 = in2 = 0.
- REQ-014 rd SHALL equal instr[11:7] for every instruction.
- REQ-015 wb_en SHALL be 1 only for a legal instruction with rd ≠ 0.
- REQ-016 An illegal instruction SHALL still complete the valid/ready handshake normally; it SHALL NOT stall the stage.

Reset
- REQ-017 While rst_n=0, the block SHALL drive out_valid=0, alu_op=0000, in1=0, in2=0, rd=0, wb_en=0 and illegal=0.
- REQ-018 Assertion of rst_n mid-transfer SHALL discard the held entry immediately (asynchronously).
- REQ-019 After reset release, the first transfer in SHALL be possible on the first rising edge.

Configuration
- REQ-020 The macro STRICT_FUNCT7_EN SHALL control funct7 checking:
  - When defined, the following SHALL set illegal=1 and wb_en=0:
    - OP with funct7 other than 0000000, or 0100000 with funct3 000 or 101.
    - SLLI with instr[31:25] ≠ 0.
    - SRLI/SRAI with instr[31:25] other than 0000000 or 0100000.
  - When undefined, funct7 SHALL be ignored except for bit 30, and these encodings SHALL decode as legal per REQ-009/REQ-010.

Verification
- REQ-021 The bench SHALL cover these directed scenarios:
  - instr=0x002081B3, rs1=5, rs2=7 -> next cycle: out_valid=1, alu_op=0000, in1=5, in2=7, rd=3, wb_en=1.
  - instr=0x40208133 -> alu_op=1000, rd=2, wb_en=1; instr=0x4030D293 -> alu_op=1101, in2=3, rd=5.
  - instr=0x123450B7 -> alu_op=0000, in1=0, in2=0x12345000, rd=1; AUIPC 0x00001017 with pc=0x100 -> in1=0x100, in2=0x1000, wb_en=0.
  - Three back-to-back valid instructions with out_ready held low for 2 cycles -> outputs held, in_ready=0, no loss and no duplication; streaming resumes at 1 per cycle.
  - instr=0x0000000F -> illegal=1, wb_en=0. With STRICT_FUNCT7_EN, instr=0x022081B3 -> illegal=1; without it -> alu_op=0000, illegal=0.
  - rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release in_ready=1.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I integer issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU controls behind a one-entry skid-free register.
// Optional macro STRICT_FUNCT7_EN flags non-base funct7 encodings as illegal.
module alu_issue #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [4:0]        rd,
  output logic              wb_en,
  output logic              illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [3:0] OP_ADD    = 4'b0000;

  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic signed [DATA_W-1:0] imm_i;
  logic signed [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0]        shamt;

  logic [3:0]               alu_op_p0;
  logic [DATA_W-1:0]        in1_p0;
  logic [DATA_W-1:0]        in2_p0;
  logic                     ill_p0;
  logic                     wb_en_p0;

  logic                     vld_p1;
  logic [3:0]               alu_op_p1;
  logic [DATA_W-1:0]        in1_p1;
  logic [DATA_W-1:0]        in2_p1;
  logic [4:0]               rd_p1;
  logic                     wb_en_p1;
  logic                     ill_p1;

  logic                     xfer_in;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{(DATA_W-11){instr[31]}}, instr[30:20]};
  assign imm_u  = {{(DATA_W-31){instr[31]}}, instr[30:12], 12'b0};
  assign shamt  = {{(DATA_W-5){1'b0}}, instr[24:20]};

  // Stage p0: combinational decode of the offered instruction
  always_comb begin
    alu_op_p0 = OP_ADD;
    in1_p0    = '0;
    in2_p0    = '0;
    ill_p0    = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op_p0 = {instr[30], funct3};
        in1_p0    = rs1_data;
        in2_p0    = rs2_data;
`ifdef STRICT_FUNCT7_EN
        if (!((instr[31:25] == 7'b0000000) ||
              ((instr[31:25] == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          ill_p0 = 1'b1;
`endif
      end
      OPC_OPIMM: begin
        in1_p0 = rs1_data;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          alu_op_p0 = {instr[30], funct3};
          in2_p0    = shamt;
`ifdef STRICT_FUNCT7_EN
          if ((funct3 == 3'b001) && (instr[31:25] != 7'b0000000))
            ill_p0 = 1'b1;
          if ((funct3 == 3'b101) && (instr[31:25] != 7'b0000000) && (instr[31:25] != 7'b0100000))
            ill_p0 = 1'b1;
`endif
        end else begin
          // bit 30 is immediate data here, never a SUB selector
          alu_op_p0 = {1'b0, funct3};
          in2_p0    = imm_i;
        end
      end
      OPC_LUI: begin
        in2_p0 = imm_u;
      end
      OPC_AUIPC: begin
        in1_p0 = pc;
        in2_p0 = imm_u;
      end
      default: ill_p0 = 1'b1;
    endcase
    if (ill_p0) begin
      alu_op_p0 = OP_ADD;
      in1_p0    = '0;
      in2_p0    = '0;
    end
  end

  assign wb_en_p0 = ~ill_p0 & (instr[11:7] != 5'd0);
  assign in_ready = ~vld_p1 | out_ready;
  assign xfer_in  = in_valid & in_ready;

  // Stage p1: registered entry presented to the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      alu_op_p1 <= OP_ADD;
      in1_p1    <= '0;
      in2_p1    <= '0;
      rd_p1     <= 5'd0;
      wb_en_p1  <= 1'b0;
      ill_p1    <= 1'b0;
    end else if (xfer_in) begin
      vld_p1    <= 1'b1;
      alu_op_p1 <= alu_op_p0;
      in1_p1    <= in1_p0;
      in2_p1    <= in2_p0;
      rd_p1     <= instr[11:7];
      wb_en_p1  <= wb_en_p0;
      ill_p1    <= ill_p0;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign alu_op    = alu_op_p1;
  assign in1       = in1_p1;
  assign in2       = in2_p1;
  assign rd        = rd_p1;
  assign wb_en     = wb_en_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, backpressure, illegal handling and async reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .in1       (in1),
    .in2       (in2),
    .rd        (rd),
    .wb_en     (wb_en),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) xfer_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // {out_valid, alu_op, in1, in2, rd, wb_en, illegal}
  function automatic logic [75:0] obs();
    return {out_valid, alu_op, in1, in2, rd, wb_en, illegal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    instr    = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [75:0] exp;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    #3;
    exp = {1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required %h", obs(), exp);
    end
    tick();
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL reset_hold_clocked: got %h, required %h", obs(), exp);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_edge();
    logic [75:0] exp;
    tick();
    exp = {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL first_add: got %h, required %h", obs(), exp);
    end
  endtask

  task automatic test_decode();
    logic [75:0] exp;
    out_ready = 1'b1;
    drive(1'b1, 32'h40208133, 32'h0, 32'd9, 32'd4);
    tick();
    exp = {1'b1, 4'b1000, 32'd9, 32'd4, 5'd2, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL sub: got %h, required %h", obs(), exp);
    end
    drive(1'b1, 32'h4030D293, 32'h0, 32'h80000000, 32'hDEADBEEF);
    tick();
    exp = {1'b1, 4'b1101, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL srai: got %h, required %h", obs(), exp);
    end
    drive(1'b1, 32'hFFF08213, 32'h0, 32'd10, 32'd20);
    tick();
    exp = {1'b1, 4'b0000, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL addi_neg: got %h, required %h", obs(), exp);
    end
    drive(1'b1, 32'h123450B7, 32'h0, 32'h11111111, 32'h22222222);
    tick();
    exp = {1'b1, 4'b0000, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL lui: got %h, required %h", obs(), exp);
    end
    drive(1'b1, 32'h00001017, 32'h100, 32'h33, 32'h44);
    tick();
    exp = {1'b1, 4'b0000, 32'h100, 32'h1000, 5'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL auipc: got %h, required %h", obs(), exp);
    end
  endtask

  task automatic test_illegal();
    logic [75:0] exp;
    drive(1'b1, 32'h0000000F, 32'h200, 32'h55, 32'h66);
    tick();
    exp = {1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL fence_illegal: got %h, required %h", obs(), exp);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_no_stall: got in_ready %b, required 1", in_ready);
    end
    drive(1'b1, 32'h022081B3, 32'h0, 32'd5, 32'd7);
    tick();
`ifdef STRICT_FUNCT7_EN
    exp = {1'b1, 4'b0000, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1};
`else
    exp = {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
`endif
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL funct7_mul: got %h, required %h", obs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [75:0] exp_a, exp_b, exp_c;
    exp_a = {1'b1, 4'b0000, 32'd1, 32'd2, 5'd10, 1'b1, 1'b0};
    exp_b = {1'b1, 4'b0000, 32'd3, 32'd4, 5'd11, 1'b1, 1'b0};
    exp_c = {1'b1, 4'b0000, 32'd5, 32'd6, 5'd12, 1'b1, 1'b0};
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: got out_valid %b, required 0", out_valid);
    end
    xfer_cnt  = 0;
    out_ready = 1'b0;
    drive(1'b1, 32'h00000533, 32'h0, 32'd1, 32'd2);
    tick();
    drive(1'b1, 32'h000005B3, 32'h0, 32'd3, 32'd4);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({obs(), in_ready} !== {exp_a, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got %h, required %h", k, {obs(), in_ready}, {exp_a, 1'b0});
      end
      tick();
    end
    n_cmp++;
    if (obs() !== exp_a) begin
      n_bad++;
      $display("FAIL stall_hold_last: got %h, required %h", obs(), exp_a);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release_in_ready: got %b, required 1", in_ready);
    end
    tick();
    n_cmp++;
    if (obs() !== exp_b) begin
      n_bad++;
      $display("FAIL stream_b: got %h, required %h", obs(), exp_b);
    end
    drive(1'b1, 32'h00000633, 32'h0, 32'd5, 32'd6);
    tick();
    n_cmp++;
    if (obs() !== exp_c) begin
      n_bad++;
      $display("FAIL stream_c: got %h, required %h", obs(), exp_c);
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_after_c: got out_valid %b, required 0", out_valid);
    end
    n_cmp++;
    if (xfer_cnt !== 3) begin
      n_bad++;
      $display("FAIL transfer_count: got %0d, required 3", xfer_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [75:0] exp;
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_setup: got out_valid %b, required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL arst_immediate: got %h, required %h", obs(), exp);
    end
    #2;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL arst_release: got %b, required 01", {out_valid, in_ready});
    end
    drive(1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h0);
    tick();
    exp = {1'b1, 4'b0000, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL arst_first_xfer: got %h, required %h", obs(), exp);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_decode();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
